// File: rtl/fib_pkg.sv
// ---------------------------------------------------------------------------
// fib_pkg
// Shared definitions for the Fibonacci register-file exercise. Used by the
// readback checker and by the write sequencer.
//   DEF_*     default data width, register count, seeds and read latency
//   NO_FAIL   fail_idx value reported when no register mismatched
//   state_t   readback checker states
// ---------------------------------------------------------------------------
package fib_pkg;

    localparam int              DEF_WIDTH    = 16;
    localparam int              DEF_NUM_REGS = 16;
    localparam int              DEF_READ_LAT = 1;
    localparam logic [15:0]     DEF_SEED0    = 16'd0;
    localparam logic [15:0]     DEF_SEED1    = 16'd1;
    localparam logic [3:0]      NO_FAIL      = 4'hF;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        COMPARE,
        DONE
    } state_t;

endpackage

// File: rtl/fib_gen.sv
// ---------------------------------------------------------------------------
// fib_gen
// Fibonacci golden-value generator. out is the current term (exp_a); exp_b
// holds the next term. Sums wrap modulo 2^WIDTH.
//   clk    rising-edge clock
//   reset  asynchronous active-low reset, reloads the seeds
//   load   reload the seeds (takes priority over step)
//   step   advance one term
//   out    current expected value
// ---------------------------------------------------------------------------
module fib_gen
    import fib_pkg::*;
#(
    parameter int              WIDTH = DEF_WIDTH,
    parameter logic [WIDTH-1:0] SEED0 = DEF_SEED0,
    parameter logic [WIDTH-1:0] SEED1 = DEF_SEED1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             step,
    output logic [WIDTH-1:0] out
);

    logic [WIDTH-1:0] exp_a;
    logic [WIDTH-1:0] exp_b;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            exp_a <= SEED0;
            exp_b <= SEED1;
        end else if (load) begin
            exp_a <= SEED0;
            exp_b <= SEED1;
        end else if (step) begin
            exp_a <= exp_b;
            exp_b <= exp_a + exp_b;
        end
    end

    assign out = exp_a;

endmodule

// File: rtl/fib_readback_checker.sv
// ---------------------------------------------------------------------------
// fib_readback_checker
// Walks the regfile read port over r0..r(NUM_REGS-1), compares each value
// with the Fibonacci golden sequence and reports the score.
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   start      level, sampled only in IDLE; begins a readback pass
//   rd_sel     regfile read-port select (held until its compare completes)
//   rd_data    regfile read-port data, valid READ_LAT cycles after rd_sel
//   busy       pass in progress
//   done       one-cycle pulse at end of pass
//   pass       1 when no register mismatched; valid from done to next start
//   fail_idx   index of first mismatch, NO_FAIL when none
//   err_count  number of mismatching registers, saturates at NUM_REGS
//
// state   | meaning
// --------+----------------------------------------------------------------
// IDLE    | waiting for start
// ISSUE   | rd_sel driven, first read-latency cycle (skipped if READ_LAT=0)
// WAIT    | remaining READ_LAT-1 latency cycles (skipped if READ_LAT<=1)
// COMPARE | rd_data scored against the generator, generator/index advance
// DONE    | done pulse, final pass flag already registered
// ---------------------------------------------------------------------------
module fib_readback_checker
    import fib_pkg::*;
#(
    parameter int               WIDTH    = DEF_WIDTH,
    parameter int               NUM_REGS = DEF_NUM_REGS,
    parameter logic [WIDTH-1:0] SEED0    = DEF_SEED0,
    parameter logic [WIDTH-1:0] SEED1    = DEF_SEED1,
    parameter int               READ_LAT = DEF_READ_LAT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    output logic [3:0]       rd_sel,
    input  logic [WIDTH-1:0] rd_data,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [3:0]       fail_idx,
    output logic [4:0]       err_count
);

    localparam logic [3:0] LAST_IDX  = 4'(NUM_REGS - 1);
    localparam logic [4:0] MAX_ERR   = 5'(NUM_REGS);
    localparam logic [1:0] WAIT_LOAD = 2'((READ_LAT >= 2) ? (READ_LAT - 2) : 0);

    state_t           state;
    state_t           state_nxt;
    logic [1:0]       lat_cnt;
    logic [1:0]       lat_cnt_nxt;
    logic [3:0]       idx;
    logic             gen_load;
    logic             gen_step;
    logic [WIDTH-1:0] exp_a;
    logic             mism;
    logic             last;

    fib_gen #(
        .WIDTH (WIDTH),
        .SEED0 (SEED0),
        .SEED1 (SEED1)
    ) u_gen (
        .clk   (clk),
        .reset (reset),
        .load  (gen_load),
        .step  (gen_step),
        .out   (exp_a)
    );

    // An unknown rd_data makes the equality X, which takes the mismatch path.
    always_comb begin
        mism = 1'b1;
        if (rd_data == exp_a) begin
            mism = 1'b0;
        end
    end

    assign last = (idx == LAST_IDX);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            lat_cnt <= 2'd0;
        end else begin
            state   <= state_nxt;
            lat_cnt <= lat_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        lat_cnt_nxt = lat_cnt;
        gen_load    = 1'b0;
        gen_step    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    gen_load  = 1'b1;
                    state_nxt = (READ_LAT == 0) ? COMPARE : ISSUE;
                end
            end
            ISSUE: begin
                if (READ_LAT <= 1) begin
                    state_nxt = COMPARE;
                end else begin
                    state_nxt   = WAIT;
                    lat_cnt_nxt = WAIT_LOAD;
                end
            end
            WAIT: begin
                if (lat_cnt == 2'd0) begin
                    state_nxt = COMPARE;
                end else begin
                    lat_cnt_nxt = lat_cnt - 2'd1;
                end
            end
            COMPARE: begin
                gen_step = 1'b1;
                if (last) begin
                    state_nxt = DONE;
                end else begin
                    state_nxt = (READ_LAT == 0) ? COMPARE : ISSUE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx       <= 4'd0;
            err_count <= 5'd0;
            fail_idx  <= NO_FAIL;
            pass      <= 1'b0;
        end else begin
            if (state == IDLE && start) begin
                idx       <= 4'd0;
                err_count <= 5'd0;
                fail_idx  <= NO_FAIL;
                pass      <= 1'b0;
            end else if (state == COMPARE) begin
                if (mism) begin
                    // err_count==0 marks the first mismatch; NO_FAIL is also a legal index.
                    if (err_count == 5'd0) begin
                        fail_idx <= idx;
                    end
                    if (err_count < MAX_ERR) begin
                        err_count <= err_count + 5'd1;
                    end
                end
                if (last) begin
                    pass <= (err_count == 5'd0) && !mism;
                end else begin
                    idx <= idx + 4'd1;
                end
            end
        end
    end

    assign rd_sel = idx;
    assign busy   = (state == ISSUE) || (state == WAIT) || (state == COMPARE);
    assign done   = (state == DONE);

endmodule

// File: tb/tb_fib_readback_checker.sv
module tb_fib_readback_checker;

    typedef struct {
        int         inst;
        logic       pass;
        logic [4:0] err;
        logic [3:0] fidx;
        int         lat;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst_n;
    logic [3:0]       start_v;
    logic [3:0]       done_v;
    logic [3:0]       busy_v;
    logic [3:0]       pass_v;
    logic [3:0][3:0]  sel_v;
    logic [3:0][3:0]  fidx_v;
    logic [3:0][4:0]  err_v;
    logic [15:0]      rd0, rd1, rd2, rd3;
    logic [15:0]      p2a, p2b;
    logic [15:0]      mem [16];

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // Regfile read ports: latency 1, 0, 3, 1 for instances 0..3.
    always @(posedge clk) rd0 <= mem[sel_v[0]];
    assign rd1 = mem[sel_v[1]];
    always @(posedge clk) begin
        p2a <= mem[sel_v[2]];
        p2b <= p2a;
        rd2 <= p2b;
    end
    always @(posedge clk) rd3 <= mem[sel_v[3]];

    fib_readback_checker #(.READ_LAT(1)) u_dut0 (
        .clk(clk), .reset(rst_n), .start(start_v[0]), .rd_sel(sel_v[0]), .rd_data(rd0),
        .busy(busy_v[0]), .done(done_v[0]), .pass(pass_v[0]), .fail_idx(fidx_v[0]),
        .err_count(err_v[0]));

    fib_readback_checker #(.READ_LAT(0)) u_dut1 (
        .clk(clk), .reset(rst_n), .start(start_v[1]), .rd_sel(sel_v[1]), .rd_data(rd1),
        .busy(busy_v[1]), .done(done_v[1]), .pass(pass_v[1]), .fail_idx(fidx_v[1]),
        .err_count(err_v[1]));

    fib_readback_checker #(.READ_LAT(3)) u_dut2 (
        .clk(clk), .reset(rst_n), .start(start_v[2]), .rd_sel(sel_v[2]), .rd_data(rd2),
        .busy(busy_v[2]), .done(done_v[2]), .pass(pass_v[2]), .fail_idx(fidx_v[2]),
        .err_count(err_v[2]));

    fib_readback_checker #(.READ_LAT(1), .SEED0(16'h8000), .SEED1(16'h8000)) u_dut3 (
        .clk(clk), .reset(rst_n), .start(start_v[3]), .rd_sel(sel_v[3]), .rd_data(rd3),
        .busy(busy_v[3]), .done(done_v[3]), .pass(pass_v[3]), .fail_idx(fidx_v[3]),
        .err_count(err_v[3]));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int rl_of(input int inst);
        case (inst)
            1:       return 0;
            2:       return 3;
            default: return 1;
        endcase
    endfunction

    function automatic exp_t model(input int inst);
        exp_t        e;
        logic [15:0] a, b, t;
        a      = (inst == 3) ? 16'h8000 : 16'h0000;
        b      = (inst == 3) ? 16'h8000 : 16'h0001;
        e.inst = inst;
        e.err  = 5'd0;
        e.fidx = 4'hF;
        for (int i = 0; i < 16; i++) begin
            if (mem[i] !== a) begin
                if (e.err == 5'd0) e.fidx = 4'(i);
                e.err = e.err + 5'd1;
            end
            t = a + b;
            a = b;
            b = t;
        end
        e.pass = (e.err == 5'd0);
        e.lat  = 16 * (rl_of(inst) + 1);
        return e;
    endfunction

    task automatic load_fib(input logic [15:0] s0, input logic [15:0] s1);
        logic [15:0] a, b, t;
        a = s0;
        b = s1;
        for (int i = 0; i < 16; i++) begin
            mem[i] = a;
            t = a + b;
            a = b;
            b = t;
        end
    endtask

    // Drives one pass on instance inst; restart_at>=0 pulses start mid-pass.
    task automatic run_pass(input int inst, input int restart_at);
        exp_t       g;
        int         cnt;
        logic [3:0] prev;
        sb.push_back(model(inst));
        @(negedge clk);
        start_v[inst] = 1'b1;
        @(posedge clk);
        #1;
        start_v[inst] = 1'b0;
        chk("busy_after_accept", busy_v[inst], 1);
        chk("rd_sel_first", sel_v[inst], 0);
        prev = 4'd0;
        cnt  = 0;
        while (done_v[inst] !== 1'b1 && cnt < 400) begin
            start_v[inst] = (cnt == restart_at);
            @(posedge clk);
            #1;
            cnt++;
            if (sel_v[inst] !== prev) begin
                chk("rd_sel_step", sel_v[inst], 4'(prev + 4'd1));
                prev = sel_v[inst];
            end
        end
        start_v[inst] = 1'b0;
        g = sb.pop_front();
        chk("done_latency", cnt, g.lat);
        chk("pass", pass_v[inst], g.pass);
        chk("err_count", err_v[inst], g.err);
        chk("fail_idx", fidx_v[inst], g.fidx);
        chk("busy_at_done", busy_v[inst], 0);
        chk("rd_sel_last", sel_v[inst], 15);
        @(posedge clk);
        #1;
        chk("done_one_cycle", done_v[inst], 0);
        repeat (3) @(posedge clk);
        #1;
        chk("pass_hold", pass_v[inst], g.pass);
        chk("err_hold", err_v[inst], g.err);
        chk("fail_idx_hold", fidx_v[inst], g.fidx);
    endtask

    task automatic chk_reset_vals(input int inst, input string tag);
        chk({tag, "_rd_sel"}, sel_v[inst], 0);
        chk({tag, "_busy"}, busy_v[inst], 0);
        chk({tag, "_done"}, done_v[inst], 0);
        chk({tag, "_pass"}, pass_v[inst], 0);
        chk({tag, "_fail_idx"}, fidx_v[inst], 4'hF);
        chk({tag, "_err"}, err_v[inst], 0);
    endtask

    initial begin
        rst_n   = 1'b0;
        start_v = 4'd0;
        load_fib(16'h0000, 16'h0001);
        repeat (2) @(posedge clk);
        #1;
        chk_reset_vals(0, "rst0");
        chk_reset_vals(2, "rst2");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("idle_busy", busy_v[0], 0);

        // Matching data on all latency variants; start re-pulsed mid-pass on inst 0.
        run_pass(0, 5);
        run_pass(1, -1);
        run_pass(2, -1);

        // Two corrupted registers.
        mem[7]  = 16'd14;
        mem[12] = 16'd0;
        run_pass(0, -1);

        // All registers zero.
        for (int i = 0; i < 16; i++) mem[i] = 16'h0000;
        run_pass(0, -1);
        run_pass(2, -1);

        // Wrapping sequence from 0x8000 seeds; r2 wraps to zero.
        load_fib(16'h8000, 16'h8000);
        run_pass(3, -1);
        mem[5] = 16'h1234;
        run_pass(3, -1);

        // Reset mid-pass with start held high.
        load_fib(16'h0000, 16'h0001);
        mem[0] = 16'd5;
        @(negedge clk);
        start_v[0] = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("pre_reset_err", err_v[0], 1);
        chk("pre_reset_busy", busy_v[0], 1);
        #1;
        rst_n = 1'b0;
        #1;
        chk_reset_vals(0, "async_rst");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_no_done", done_v[0], 0);
        end
        start_v[0] = 1'b0;
        rst_n      = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("post_rst_idle", busy_v[0], 0);
        chk("post_rst_no_done", done_v[0], 0);
        mem[0] = 16'd0;
        run_pass(0, -1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
